// File: rtl/butterfly_fft_top.sv
// Two independent 8-point radix-2 DIT FFT banks (ports 0-7 and 8-15) with a
// toggle-triggered, three-stage registered pipeline and a ready flag.
module butterfly_fft_top #(
    parameter int TW_FRAC = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_input_flag,
    input  logic signed [15:0] input_real0,  input_real1,  input_real2,  input_real3,
    input  logic signed [15:0] input_real4,  input_real5,  input_real6,  input_real7,
    input  logic signed [15:0] input_real8,  input_real9,  input_real10, input_real11,
    input  logic signed [15:0] input_real12, input_real13, input_real14, input_real15,
    input  logic signed [15:0] input_imag0,  input_imag1,  input_imag2,  input_imag3,
    input  logic signed [15:0] input_imag4,  input_imag5,  input_imag6,  input_imag7,
    input  logic signed [15:0] input_imag8,  input_imag9,  input_imag10, input_imag11,
    input  logic signed [15:0] input_imag12, input_imag13, input_imag14, input_imag15,
    output logic signed [15:0] output_real0,  output_real1,  output_real2,  output_real3,
    output logic signed [15:0] output_real4,  output_real5,  output_real6,  output_real7,
    output logic signed [15:0] output_real8,  output_real9,  output_real10, output_real11,
    output logic signed [15:0] output_real12, output_real13, output_real14, output_real15,
    output logic signed [15:0] output_imag0,  output_imag1,  output_imag2,  output_imag3,
    output logic signed [15:0] output_imag4,  output_imag5,  output_imag6,  output_imag7,
    output logic signed [15:0] output_imag8,  output_imag9,  output_imag10, output_imag11,
    output logic signed [15:0] output_imag12, output_imag13, output_imag14, output_imag15,
    output logic               fft_ready_flag
);
    // state | meaning
    // IDLE  | no conversion since reset
    // S1    | stage 0 loaded, computing butterfly stage 1
    // S2    | computing butterfly stage 2
    // S3    | computing stage 3 into the output registers
    // DONE  | outputs valid, waiting for the next toggle
    typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;
    typedef logic [7:0][15:0] bank_t;

    localparam logic signed [15:0] TW_RE [4] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
    localparam logic signed [15:0] TW_IM [4] = '{16'sd0, -16'sd11585, -16'sd16384, -16'sd11585};

    state_t state_q, state_d;
    logic   flag_q, start, load, do1, do2, do3;
    bank_t  in_re [2], in_im [2];
    bank_t  s0_re [2], s0_im [2], s1_re [2], s1_im [2], s2_re [2], s2_im [2];
    bank_t  n1_re [2], n1_im [2], n2_re [2], n2_im [2], n3_re [2], n3_im [2];
    bank_t  out_re [2], out_im [2];

    // One butterfly stage of span h (1, 2 or 4) over a bit-reversed bank.
    function automatic void bfly_stage(input bank_t ar, input bank_t ai, input int h,
                                       output bank_t yr, output bank_t yi);
        logic signed [15:0] br, bi, wr, wi, pr, pi;
        logic signed [31:0] mr, mi;
        logic [2:0] top, bot;
        logic [1:0] tw;
        yr = '0;
        yi = '0;
        for (int k = 0; k < 4; k++) begin
            top = 3'((k / h) * 2 * h + (k % h));
            bot = 3'(int'(top) + h);
            tw  = 2'((k % h) * (4 / h));
            br  = ar[bot];
            bi  = ai[bot];
            wr  = TW_RE[tw];
            wi  = TW_IM[tw];
            mr  = 32'(br) * 32'(wr) - 32'(bi) * 32'(wi);
            mi  = 32'(br) * 32'(wi) + 32'(bi) * 32'(wr);
            pr  = mr[TW_FRAC+15:TW_FRAC];
            pi  = mi[TW_FRAC+15:TW_FRAC];
            yr[top] = ar[top] + pr;
            yi[top] = ai[top] + pi;
            yr[bot] = ar[top] - pr;
            yi[bot] = ai[top] - pi;
        end
    endfunction

    assign in_re[0] = {input_real7, input_real6, input_real5, input_real4,
                       input_real3, input_real2, input_real1, input_real0};
    assign in_re[1] = {input_real15, input_real14, input_real13, input_real12,
                       input_real11, input_real10, input_real9, input_real8};
    assign in_im[0] = {input_imag7, input_imag6, input_imag5, input_imag4,
                       input_imag3, input_imag2, input_imag1, input_imag0};
    assign in_im[1] = {input_imag15, input_imag14, input_imag13, input_imag12,
                       input_imag11, input_imag10, input_imag9, input_imag8};

    assign start = (new_input_flag != flag_q);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bfly_stage(s0_re[b], s0_im[b], 1, n1_re[b], n1_im[b]);
            bfly_stage(s1_re[b], s1_im[b], 2, n2_re[b], n2_im[b]);
            bfly_stage(s2_re[b], s2_im[b], 4, n3_re[b], n3_im[b]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= new_input_flag;
        end
    end

    // A toggle wins over stage advancement so a restart discards any partial result.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        do1     = 1'b0;
        do2     = 1'b0;
        do3     = 1'b0;
        if (start) begin
            load    = 1'b1;
            state_d = S1;
        end else begin
            case (state_q)
                S1:      begin do1 = 1'b1; state_d = S2;   end
                S2:      begin do2 = 1'b1; state_d = S3;   end
                S3:      begin do3 = 1'b1; state_d = DONE; end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                s0_re[b]  <= '0; s0_im[b]  <= '0;
                s1_re[b]  <= '0; s1_im[b]  <= '0;
                s2_re[b]  <= '0; s2_im[b]  <= '0;
                out_re[b] <= '0; out_im[b] <= '0;
            end
            fft_ready_flag <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (load) begin
                    for (int i = 0; i < 8; i++) begin
                        s0_re[b][i] <= in_re[b][{i[0], i[1], i[2]}];
                        s0_im[b][i] <= in_im[b][{i[0], i[1], i[2]}];
                    end
                end
                if (do1) begin s1_re[b]  <= n1_re[b]; s1_im[b]  <= n1_im[b]; end
                if (do2) begin s2_re[b]  <= n2_re[b]; s2_im[b]  <= n2_im[b]; end
                if (do3) begin out_re[b] <= n3_re[b]; out_im[b] <= n3_im[b]; end
            end
            if (load)
                fft_ready_flag <= 1'b0;
            else if (do3)
                fft_ready_flag <= 1'b1;
        end
    end

    assign output_real0  = out_re[0][0]; assign output_real1  = out_re[0][1];
    assign output_real2  = out_re[0][2]; assign output_real3  = out_re[0][3];
    assign output_real4  = out_re[0][4]; assign output_real5  = out_re[0][5];
    assign output_real6  = out_re[0][6]; assign output_real7  = out_re[0][7];
    assign output_real8  = out_re[1][0]; assign output_real9  = out_re[1][1];
    assign output_real10 = out_re[1][2]; assign output_real11 = out_re[1][3];
    assign output_real12 = out_re[1][4]; assign output_real13 = out_re[1][5];
    assign output_real14 = out_re[1][6]; assign output_real15 = out_re[1][7];
    assign output_imag0  = out_im[0][0]; assign output_imag1  = out_im[0][1];
    assign output_imag2  = out_im[0][2]; assign output_imag3  = out_im[0][3];
    assign output_imag4  = out_im[0][4]; assign output_imag5  = out_im[0][5];
    assign output_imag6  = out_im[0][6]; assign output_imag7  = out_im[0][7];
    assign output_imag8  = out_im[1][0]; assign output_imag9  = out_im[1][1];
    assign output_imag10 = out_im[1][2]; assign output_imag11 = out_im[1][3];
    assign output_imag12 = out_im[1][4]; assign output_imag13 = out_im[1][5];
    assign output_imag14 = out_im[1][6]; assign output_imag15 = out_im[1][7];
endmodule

// File: tb/tb_butterfly_fft_top.sv
// Directed-vector bench for butterfly_fft_top: table of transforms plus
// back-to-back restart and mid-conversion reset sequences.
module tb_butterfly_fft_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flag = 1'b0;
    logic        ready;
    logic [15:0] din_re [16], din_im [16], dout_re [16], dout_im [16];

    typedef struct {
        logic [15:0][15:0] in_re, in_im, ex_re, ex_im;
        int                tol;
    } vec_t;

    vec_t vecs [5];
    int   n_vec = 0;
    int   n_err = 0;
    int   prev  = -1;

    butterfly_fft_top #(.TW_FRAC(14)) dut (
        .clk(clk), .rst(rst), .new_input_flag(flag),
        .input_real0(din_re[0]),   .input_real1(din_re[1]),   .input_real2(din_re[2]),   .input_real3(din_re[3]),
        .input_real4(din_re[4]),   .input_real5(din_re[5]),   .input_real6(din_re[6]),   .input_real7(din_re[7]),
        .input_real8(din_re[8]),   .input_real9(din_re[9]),   .input_real10(din_re[10]), .input_real11(din_re[11]),
        .input_real12(din_re[12]), .input_real13(din_re[13]), .input_real14(din_re[14]), .input_real15(din_re[15]),
        .input_imag0(din_im[0]),   .input_imag1(din_im[1]),   .input_imag2(din_im[2]),   .input_imag3(din_im[3]),
        .input_imag4(din_im[4]),   .input_imag5(din_im[5]),   .input_imag6(din_im[6]),   .input_imag7(din_im[7]),
        .input_imag8(din_im[8]),   .input_imag9(din_im[9]),   .input_imag10(din_im[10]), .input_imag11(din_im[11]),
        .input_imag12(din_im[12]), .input_imag13(din_im[13]), .input_imag14(din_im[14]), .input_imag15(din_im[15]),
        .output_real0(dout_re[0]),   .output_real1(dout_re[1]),   .output_real2(dout_re[2]),   .output_real3(dout_re[3]),
        .output_real4(dout_re[4]),   .output_real5(dout_re[5]),   .output_real6(dout_re[6]),   .output_real7(dout_re[7]),
        .output_real8(dout_re[8]),   .output_real9(dout_re[9]),   .output_real10(dout_re[10]), .output_real11(dout_re[11]),
        .output_real12(dout_re[12]), .output_real13(dout_re[13]), .output_real14(dout_re[14]), .output_real15(dout_re[15]),
        .output_imag0(dout_im[0]),   .output_imag1(dout_im[1]),   .output_imag2(dout_im[2]),   .output_imag3(dout_im[3]),
        .output_imag4(dout_im[4]),   .output_imag5(dout_im[5]),   .output_imag6(dout_im[6]),   .output_imag7(dout_im[7]),
        .output_imag8(dout_im[8]),   .output_imag9(dout_im[9]),   .output_imag10(dout_im[10]), .output_imag11(dout_im[11]),
        .output_imag12(dout_im[12]), .output_imag13(dout_im[13]), .output_imag14(dout_im[14]), .output_imag15(dout_im[15]),
        .fft_ready_flag(ready)
    );

    function automatic logic [15:0] s16(input int v);
        return v[15:0];
    endfunction

    task automatic set_in(input int vi, input int k, input int re, input int im);
        vecs[vi].in_re[k] = s16(re);
        vecs[vi].in_im[k] = s16(im);
    endtask

    task automatic set_ex(input int vi, input int k, input int re, input int im);
        vecs[vi].ex_re[k] = s16(re);
        vecs[vi].ex_im[k] = s16(im);
    endtask

    task automatic chk(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] exp, input int tol);
        int diff;
        diff = int'($signed(act)) - int'($signed(exp));
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, required %0d (tol %0d)", name, k,
                     $signed(act), $signed(exp), tol);
        end
    endtask

    task automatic chk_ready(input string name, input logic exp);
        if (ready !== exp) begin
            n_err++;
            $display("FAIL %s: fft_ready_flag got %b, required %b", name, ready, exp);
        end
    endtask

    // vi < 0 means every output must be zero.
    task automatic chk_outs(input string name, input int vi);
        for (int k = 0; k < 16; k++) begin
            if (vi < 0) begin
                chk({name, "_re"}, k, dout_re[k], 16'h0, 0);
                chk({name, "_im"}, k, dout_im[k], 16'h0, 0);
            end else begin
                chk({name, "_re"}, k, dout_re[k], vecs[vi].ex_re[k], vecs[vi].tol);
                chk({name, "_im"}, k, dout_im[k], vecs[vi].ex_im[k], vecs[vi].tol);
            end
        end
    endtask

    task automatic drive(input int vi);
        for (int k = 0; k < 16; k++) begin
            din_re[k] = vecs[vi].in_re[k];
            din_im[k] = vecs[vi].in_im[k];
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < 16; k++) begin
            din_re[k] = 16'($urandom);
            din_im[k] = 16'($urandom);
        end
    endtask

    task automatic apply(input int vi);
        @(negedge clk);
        drive(vi);
        flag = ~flag;
        @(posedge clk); #1;
        chk_ready("ready_at_E", 1'b0);
        chk_outs("hold_E", prev);
        scramble();
        @(posedge clk); #1;
        chk_ready("ready_E1", 1'b0);
        @(posedge clk); #1;
        chk_ready("ready_E2", 1'b0);
        chk_outs("hold_E2", prev);
        @(posedge clk); #1;
        chk_ready("ready_E3", 1'b1);
        chk_outs($sformatf("vec%0d", vi), vi);
        prev = vi;
        n_vec++;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            vecs[i].in_re = '0; vecs[i].in_im = '0;
            vecs[i].ex_re = '0; vecs[i].ex_im = '0;
            vecs[i].tol   = 0;
        end
        // 0: impulse on bank A
        set_in(0, 0, 1000, 0);
        for (int k = 0; k < 8; k++) set_ex(0, k, 1000, 0);
        // 1: DC on bank B
        for (int k = 8; k < 16; k++) set_in(1, k, 100, 0);
        set_ex(1, 8, 800, 0);
        vecs[1].tol = 1;
        // 2: reference vector on bank A
        set_in(2, 0, 3000, -2000); set_in(2, 1, 23, 0);   set_in(2, 2, -4000, -1500);
        set_in(2, 3, 9000, 8);     set_in(2, 4, 1, 5);    set_in(2, 5, 2, 6);
        set_in(2, 6, 3, 7);        set_in(2, 7, 4, 8);
        set_ex(2, 0, 8033, -3466);  set_ex(2, 1, -4859, -4382); set_ex(2, 2, 6988, 8477);
        set_ex(2, 3, 10848, -12380); set_ex(2, 4, -10025, -3510); set_ex(2, 5, 7843, 8378);
        set_ex(2, 6, 7008, -9481);  set_ex(2, 7, -1836, 364);
        vecs[2].tol = 8;
        // 3: bank A wraps at the last stage (64000 -> -1536); bank B full-scale impulse
        for (int k = 0; k < 8; k++) set_in(3, k, 8000, 0);
        set_in(3, 8, -32768, 0);
        set_ex(3, 0, -1536, 0);
        for (int k = 8; k < 16; k++) set_ex(3, k, -32768, 0);
        // 4: delayed impulses exercise every twiddle on both banks
        set_in(4, 1, 1000, 0);
        set_in(4, 9, 0, 500);
        set_ex(4, 0, 1000, 0);   set_ex(4, 1, 707, -707);  set_ex(4, 2, 0, -1000);
        set_ex(4, 3, -707, -707); set_ex(4, 4, -1000, 0);  set_ex(4, 5, -707, 707);
        set_ex(4, 6, 0, 1000);   set_ex(4, 7, 707, 707);
        set_ex(4, 8, 0, 500);    set_ex(4, 9, 354, 354);   set_ex(4, 10, 500, 0);
        set_ex(4, 11, 354, -354); set_ex(4, 12, 0, -500);  set_ex(4, 13, -354, -354);
        set_ex(4, 14, -500, 0);  set_ex(4, 15, -354, 354);
        vecs[4].tol = 2;

        // reset with arbitrary inputs
        scramble();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_ready("reset_ready", 1'b0);
        chk_outs("reset", -1);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_ready("post_reset_ready", 1'b0);
        chk_outs("post_reset", -1);
        n_vec++;

        for (int i = 0; i < 5; i++) apply(i);

        // back-to-back toggles: only the second data set may appear
        @(negedge clk);
        drive(3);
        flag = ~flag;
        @(posedge clk); #1;
        chk_ready("b2b_E1", 1'b0);
        @(negedge clk);
        drive(1);
        flag = ~flag;
        @(posedge clk); #1;
        chk_ready("b2b_E2", 1'b0);
        scramble();
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            chk_ready($sformatf("b2b_E2p%0d", c), 1'b0);
            chk_outs($sformatf("b2b_hold%0d", c), prev);
        end
        @(posedge clk); #1;
        chk_ready("b2b_E2p3", 1'b1);
        chk_outs("b2b_result", 1);
        repeat (3) @(posedge clk);
        #1;
        chk_ready("done_hold_ready", 1'b1);
        chk_outs("done_hold", 1);
        prev = 1;
        n_vec++;

        // reset asserted at E+1 kills the conversion
        @(negedge clk);
        drive(0);
        flag = ~flag;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        flag = 1'b0;
        #1;
        chk_ready("midrst_ready", 1'b0);
        chk_outs("midrst", -1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk_ready("midrst_after_ready", 1'b0);
        chk_outs("midrst_after", -1);
        prev = -1;
        n_vec++;

        apply(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
